// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch unit with PC/IR and next-PC selection.
// Status flags are registered from the next state so they never glitch on inputs.
module busca_instrucao (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  MemEnd,
    output logic        MemReq,
    input  logic        MemPronto,
    input  logic [15:0] MemDado,
    input  logic        Avanca,
    input  logic        Halt,
    input  logic        Salto,
    input  logic        Beq,
    input  logic        Zero,
    output logic [3:0]  OpCode,
    output logic [3:0]  Rs,
    output logic [3:0]  Rt,
    output logic [3:0]  Imm,
    output logic        InstrValida,
    output logic [7:0]  PC,
    output logic        Parado
);
    typedef enum logic [1:0] {INICIO, BUSCA, VALIDA, PARADO} state_t;
    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [15:0] ir, ir_nxt;
    logic        mem_req, instr_valida, parado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= INICIO;
            pc           <= 8'h00;
            ir           <= 16'h0000;
            mem_req      <= 1'b0;
            instr_valida <= 1'b0;
            parado       <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            ir           <= ir_nxt;
            mem_req      <= state_nxt == BUSCA;
            instr_valida <= state_nxt == VALIDA;
            parado       <= state_nxt == PARADO;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            INICIO: state_nxt = BUSCA;
            BUSCA: if (MemPronto) begin
                ir_nxt    = MemDado;
                state_nxt = VALIDA;
            end
            VALIDA: if (Avanca) begin
                state_nxt = Halt ? PARADO : BUSCA;
                // branch offset is the sign-extended Imm field relative to PC+1
                pc_nxt    = Halt ? pc :
                            Salto ? ir[7:0] :
                            (Beq && Zero) ? pc + 8'd1 + {{4{ir[3]}}, ir[3:0]} :
                            pc + 8'd1;
            end
            default: state_nxt = PARADO;
        endcase
    end

    assign MemEnd      = pc;
    assign PC          = pc;
    assign MemReq      = mem_req;
    assign InstrValida = instr_valida;
    assign Parado      = parado;
    assign OpCode      = ir[15:12];
    assign Rs          = ir[11:8];
    assign Rt          = ir[7:4];
    assign Imm         = ir[3:0];
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed plus randomized fetch/execute sequences
// checked against a transaction-level model of PC and IR.
module tb_busca_instrucao;
    logic        clock = 0, reset = 0;
    logic [7:0]  MemEnd, PC;
    logic        MemReq, MemPronto = 0, Avanca = 0, Halt = 0, Salto = 0, Beq = 0, Zero = 0;
    logic [15:0] MemDado = 0;
    logic [3:0]  OpCode, Rs, Rt, Imm;
    logic        InstrValida, Parado;
    int          total = 0, bad = 0;
    int          exp_pc = 0;
    logic [15:0] exp_ir = 0;

    busca_instrucao dut (
        .clock(clock), .reset(reset), .MemEnd(MemEnd), .MemReq(MemReq),
        .MemPronto(MemPronto), .MemDado(MemDado), .Avanca(Avanca), .Halt(Halt),
        .Salto(Salto), .Beq(Beq), .Zero(Zero), .OpCode(OpCode), .Rs(Rs), .Rt(Rt),
        .Imm(Imm), .InstrValida(InstrValida), .PC(PC), .Parado(Parado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_next_pc(input int pc, input logic [15:0] ir, input bit s, input bit b, input bit z);
        int off;
        off = (ir[3:0] >= 8) ? int'(ir[3:0]) - 16 : int'(ir[3:0]);
        if (s) return int'(ir[7:0]);
        if (b && z) return (pc + 1 + off + 256) % 256;
        return (pc + 1) % 256;
    endfunction

    task automatic fetch(input int waits, input logic [15:0] d);
        for (int i = 0; i < waits; i++) begin
            MemPronto = 0;
            MemDado = 16'($urandom);
            chk("busca_req", MemReq, 1);
            chk("busca_end", MemEnd, exp_pc);
            chk("busca_iv", InstrValida, 0);
            tick();
        end
        MemPronto = 1;
        MemDado = d;
        chk("busca_req_last", MemReq, 1);
        tick();
        MemPronto = 0;
        exp_ir = d;
        chk("fetch_iv", InstrValida, 1);
        chk("fetch_req", MemReq, 0);
        chk("fetch_ir", {OpCode, Rs, Rt, Imm}, exp_ir);
        chk("fetch_pc", PC, exp_pc);
    endtask

    task automatic exec(input int waits, input bit h, input bit s, input bit b, input bit z);
        for (int i = 0; i < waits; i++) begin
            Avanca = 0;
            {Halt, Salto, Beq, Zero} = 4'($urandom);
            MemPronto = 1'($urandom);
            MemDado = 16'($urandom);
            tick();
            chk("valida_hold_iv", InstrValida, 1);
            chk("valida_hold_ir", {OpCode, Rs, Rt, Imm}, exp_ir);
            chk("valida_hold_pc", PC, exp_pc);
            chk("valida_hold_req", MemReq, 0);
        end
        MemPronto = 0;
        Avanca = 1;
        {Halt, Salto, Beq, Zero} = {h, s, b, z};
        tick();
        Avanca = 0;
        {Halt, Salto, Beq, Zero} = 4'b0;
        if (!h) exp_pc = model_next_pc(exp_pc, exp_ir, s, b, z);
        chk("exec_pc", PC, exp_pc);
        chk("exec_end", MemEnd, exp_pc);
        chk("exec_req", MemReq, !h);
        chk("exec_parado", Parado, h);
        chk("exec_iv", InstrValida, 0);
    endtask

    initial begin
        #3;
        chk("rst_pc", PC, 0);
        chk("rst_ir", {OpCode, Rs, Rt, Imm}, 0);
        chk("rst_flags", {MemReq, InstrValida, Parado}, 0);
        @(negedge clock);
        reset = 1;
        tick();
        chk("first_req", MemReq, 1);
        chk("first_end", MemEnd, 0);
        fetch(2, 16'h1234);
        chk("op", OpCode, 1);
        chk("rs", Rs, 2);
        chk("rt", Rt, 3);
        chk("imm", Imm, 4);
        exec(1, 0, 0, 0, 0);
        for (int n = 0; n < 25; n++) begin
            fetch($urandom_range(0, 3), 16'($urandom));
            exec($urandom_range(0, 3), 0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        fetch(0, 16'h40FF);
        exec(0, 0, 1, 0, 0);
        fetch(1, 16'h7777);
        exec(0, 0, 0, 0, 0);
        chk("wrap_pc", PC, 0);
        chk("wrap_end", MemEnd, 0);
        fetch(0, 16'h30F0);
        exec(0, 0, 1, 1, 1);
        chk("salto_beats_beq", PC, 8'hF0);
        fetch(0, 16'h0010);
        exec(0, 0, 1, 0, 0);
        fetch(0, 16'h500E);
        exec(0, 0, 0, 1, 1);
        chk("beq_taken", PC, 8'h0F);
        fetch(0, 16'h500E);
        exec(0, 0, 0, 1, 0);
        fetch(0, 16'h500E);
        exec(0, 0, 0, 1, 0);
        chk("beq_not_taken", PC, 8'h11);
        MemPronto = 1;
        MemDado = 16'hFFFF;
        #2 reset = 0;
        #1;
        chk("async_rst_ir", {OpCode, Rs, Rt, Imm}, 0);
        chk("async_rst_pc", PC, 0);
        chk("async_rst_flags", {MemReq, InstrValida, Parado}, 0);
        tick();
        #2 reset = 1;
        tick();
        chk("post_rst_ir", {OpCode, Rs, Rt, Imm}, 0);
        chk("post_rst_iv", InstrValida, 0);
        chk("post_rst_req", MemReq, 1);
        exp_pc = 0;
        exp_ir = 0;
        fetch(1, 16'h2345);
        exec(0, 0, 0, 0, 0);
        fetch(0, 16'h9ABC);
        exec(2, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            {MemPronto, Avanca, Halt, Salto, Beq, Zero} = 6'($urandom);
            MemDado = 16'($urandom);
            tick();
            chk("halt_req", MemReq, 0);
            chk("halt_parado", Parado, 1);
            chk("halt_pc", PC, exp_pc);
            chk("halt_ir", {OpCode, Rs, Rt, Imm}, exp_ir);
            chk("halt_iv", InstrValida, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
